// File: rtl/reorder_buffer_if.sv
// Bundle of the reorder buffer's dispatch, CDB, operand lookup and
// write-back/flush signals. The ROB takes the slave side; the pipeline
// (or a bench) drives the master side.
interface reorder_buffer_if #(
   parameter int TAGW = 5
);
   logic            alloc_valid;
   logic            alloc_ready;
   logic [4:0]      alloc_rd;
   logic            alloc_is_br;
   logic [TAGW-1:0] alloc_tag;

   logic            cdb_valid;
   logic [TAGW-1:0] cdb_tag;
   logic [31:0]     cdb_data;
   logic            cdb_mispredict;
   logic [31:0]     cdb_target;

   logic [TAGW-1:0] q_tag_a;
   logic [TAGW-1:0] q_tag_b;
   logic            q_ready_a;
   logic            q_ready_b;
   logic [31:0]     q_data_a;
   logic [31:0]     q_data_b;

   logic            load_wb;
   logic [4:0]      wb_dest;
   logic [31:0]     wb_data;
   logic [TAGW-1:0] wb_tag;
   logic            flush;
   logic [31:0]     redirect_pc;

   modport slave (
      input  alloc_valid, alloc_rd, alloc_is_br,
      output alloc_ready, alloc_tag,
      input  cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
      input  q_tag_a, q_tag_b,
      output q_ready_a, q_ready_b, q_data_a, q_data_b,
      output load_wb, wb_dest, wb_data, wb_tag, flush, redirect_pc
   );

   modport master (
      output alloc_valid, alloc_rd, alloc_is_br,
      input  alloc_ready, alloc_tag,
      output cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
      output q_tag_a, q_tag_b,
      input  q_ready_a, q_ready_b, q_data_a, q_data_b,
      input  load_wb, wb_dest, wb_data, wb_tag, flush, redirect_pc
   );
endinterface

// File: rtl/reorder_buffer.sv
// In-order commit queue. Hands out tag = index + 1 at dispatch (tag 0 means
// "value already in the register file"), captures results off the CDB,
// retires the head once its result is in, and flushes everything when a
// mispredicted branch reaches commit.
module reorder_buffer #(
   parameter int DEPTH = 8,
   parameter int TAGW  = 5
) (
   input logic              clk,
   input logic              rst,
   reorder_buffer_if.slave  bus
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [IW-1:0]    head;
   logic [IW-1:0]    tail;
   logic [CW-1:0]    count;
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] done;
   logic [DEPTH-1:0] is_br;
   logic [DEPTH-1:0] mispred;
   logic [4:0]       rd     [DEPTH];
   logic [31:0]      data   [DEPTH];
   logic [31:0]      target [DEPTH];

   logic             commit;
   logic             flush_now;
   logic             alloc_fire;
   logic [DEPTH-1:0] cdb_hit;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
      if (idx == IW'(DEPTH - 1)) return '0;
      return idx + IW'(1);
   endfunction

   // Head retires only on a result captured in an earlier cycle; the
   // registered done bit makes a same-cycle CDB write wait one cycle.
   assign commit          = busy[head] & done[head];
   assign flush_now       = commit & mispred[head];
   assign bus.alloc_ready = (count < CW'(DEPTH)) && !flush_now;
   assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
   assign bus.alloc_tag   = TAGW'(tail) + TAGW'(1);

   assign bus.load_wb     = commit;
   assign bus.wb_dest     = commit ? rd[head] : '0;
   assign bus.wb_data     = commit ? data[head] : '0;
   assign bus.wb_tag      = TAGW'(head) + TAGW'(1);
   assign bus.flush       = flush_now;
   assign bus.redirect_pc = flush_now ? target[head] : '0;

   // CDB tag decode; tags 0 and above DEPTH match no entry and drop out.
   always_comb begin
      cdb_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cdb_hit[i] = bus.cdb_valid && (bus.cdb_tag == TAGW'(i + 1)) && busy[i];
      end
   end

   // Operand lookup for the two source tags; no bypass from the live CDB.
   always_comb begin
      bus.q_ready_a = 1'b0;
      bus.q_data_a  = '0;
      bus.q_ready_b = 1'b0;
      bus.q_data_b  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.q_tag_a == TAGW'(i + 1) && busy[i] && done[i]) begin
            bus.q_ready_a = 1'b1;
            bus.q_data_a  = data[i];
         end
         if (bus.q_tag_b == TAGW'(i + 1) && busy[i] && done[i]) begin
            bus.q_ready_b = 1'b1;
            bus.q_data_b  = data[i];
         end
      end
   end

   // Control state: pointers, occupancy and per-entry status bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         busy    <= '0;
         done    <= '0;
         mispred <= '0;
      end else if (flush_now) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         busy    <= '0;
         done    <= '0;
         mispred <= '0;
      end else begin
         if (alloc_fire) begin
            busy[tail]    <= 1'b1;
            done[tail]    <= 1'b0;
            mispred[tail] <= 1'b0;
            tail          <= wrap_inc(tail);
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (cdb_hit[i]) begin
               done[i]    <= 1'b1;
               mispred[i] <= bus.cdb_mispredict & is_br[i];
            end
         end
         if (commit) begin
            busy[head] <= 1'b0;
            head       <= wrap_inc(head);
         end
         case ({alloc_fire, commit})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage; only meaningful while the entry is busy, so no reset.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         rd[tail]    <= bus.alloc_rd;
         is_br[tail] <= bus.alloc_is_br;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (cdb_hit[i]) begin
            data[i]   <= bus.cdb_data;
            target[i] <= bus.cdb_target;
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: inputs change just after the falling
// edge, outputs are checked 1 time unit later, well away from the rising edge.
module tb_reorder_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   reorder_buffer_if #(.TAGW(5)) bus ();

   reorder_buffer #(.DEPTH(8), .TAGW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.alloc_valid    = 1'b0;
      bus.alloc_rd       = '0;
      bus.alloc_is_br    = 1'b0;
      bus.cdb_valid      = 1'b0;
      bus.cdb_tag        = '0;
      bus.cdb_data       = '0;
      bus.cdb_mispredict = 1'b0;
      bus.cdb_target     = '0;
      bus.q_tag_a        = '0;
      bus.q_tag_b        = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic dispatch(input logic [4:0] rd, input logic br);
      bus.alloc_valid = 1'b1;
      bus.alloc_rd    = rd;
      bus.alloc_is_br = br;
      tick();
      bus.alloc_valid = 1'b0;
      bus.alloc_is_br = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (bus.alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_alloc_ready got %0b exp 1", bus.alloc_ready); end
      tests++; if (bus.alloc_tag !== 5'd1) begin fails++; $display("FAIL reset_alloc_tag got %0d exp 1", bus.alloc_tag); end
      tests++; if (bus.load_wb !== 1'b0 || bus.flush !== 1'b0) begin fails++; $display("FAIL reset_wb_flush got %0b/%0b exp 0/0", bus.load_wb, bus.flush); end
      tests++; if (bus.wb_dest !== 5'd0 || bus.wb_data !== 32'd0 || bus.wb_tag !== 5'd1) begin fails++; $display("FAIL reset_wb got %0d/%h/%0d exp 0/0/1", bus.wb_dest, bus.wb_data, bus.wb_tag); end
      tests++; if (bus.redirect_pc !== 32'd0 || bus.q_ready_a !== 1'b0 || bus.q_data_a !== 32'd0) begin fails++; $display("FAIL reset_misc got %h/%0b/%h exp 0/0/0", bus.redirect_pc, bus.q_ready_a, bus.q_data_a); end
   endtask

   task automatic test_basic();
      do_reset();
      bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd5; #1;
      tests++; if (bus.alloc_tag !== 5'd1) begin fails++; $display("FAIL basic_alloc_tag got %0d exp 1", bus.alloc_tag); end
      tick();
      bus.alloc_valid = 1'b0;
      bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd1; bus.cdb_data = 32'hDEADBEEF; #1;
      tests++; if (bus.load_wb !== 1'b0) begin fails++; $display("FAIL basic_same_cycle_cdb got %0b exp 0", bus.load_wb); end
      tick();
      bus.cdb_valid = 1'b0; #1;
      tests++; if (bus.load_wb !== 1'b1 || bus.wb_dest !== 5'd5 || bus.wb_data !== 32'hDEADBEEF || bus.wb_tag !== 5'd1) begin
         fails++; $display("FAIL basic_commit got %0b/%0d/%h/%0d exp 1/5/deadbeef/1", bus.load_wb, bus.wb_dest, bus.wb_data, bus.wb_tag); end
      tick(); #1;
      tests++; if (bus.load_wb !== 1'b0 || bus.wb_tag !== 5'd2) begin fails++; $display("FAIL basic_after got %0b/%0d exp 0/2", bus.load_wb, bus.wb_tag); end
   endtask

   task automatic test_out_of_order();
      logic [4:0]  exp_tag  [3];
      logic [31:0] exp_data [3];
      exp_tag  = '{5'd1, 5'd2, 5'd3};
      exp_data = '{32'd11, 32'd22, 32'd33};
      do_reset();
      dispatch(5'd1, 1'b0);
      dispatch(5'd2, 1'b0);
      dispatch(5'd3, 1'b0);
      bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd3; bus.cdb_data = 32'd33; #1;
      tick();
      bus.cdb_tag = 5'd1; bus.cdb_data = 32'd11; #1;
      tests++; if (bus.load_wb !== 1'b0) begin fails++; $display("FAIL ooo_no_commit_tag3 got %0b exp 0", bus.load_wb); end
      tick();
      bus.cdb_tag = 5'd2; bus.cdb_data = 32'd22; #1;
      for (int k = 0; k < 3; k++) begin
         tests++; if (bus.load_wb !== 1'b1 || bus.wb_tag !== exp_tag[k] || bus.wb_data !== exp_data[k] || bus.wb_dest !== exp_tag[k]) begin
            fails++; $display("FAIL ooo_commit_%0d got %0b/%0d/%0d exp 1/%0d/%0d", k, bus.load_wb, bus.wb_tag, bus.wb_data, exp_tag[k], exp_data[k]); end
         tick();
         bus.cdb_valid = 1'b0; #1;
      end
      tests++; if (bus.load_wb !== 1'b0) begin fails++; $display("FAIL ooo_drained got %0b exp 0", bus.load_wb); end
   endtask

   task automatic test_full();
      do_reset();
      for (int k = 0; k < 8; k++) dispatch(5'(k + 1), 1'b0);
      bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd31; #1;
      tests++; if (bus.alloc_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %0b exp 0", bus.alloc_ready); end
      tests++; if (bus.alloc_tag !== 5'd1) begin fails++; $display("FAIL full_tag_wrap got %0d exp 1", bus.alloc_tag); end
      tick();
      bus.alloc_valid = 1'b0;
      bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd1; bus.cdb_data = 32'd100;
      tick();
      bus.cdb_valid = 1'b0; #1;
      tests++; if (bus.load_wb !== 1'b1 || bus.alloc_ready !== 1'b0 || bus.wb_data !== 32'd100 || bus.wb_dest !== 5'd1) begin
         fails++; $display("FAIL full_commit got %0b/%0b/%0d/%0d exp 1/0/100/1", bus.load_wb, bus.alloc_ready, bus.wb_data, bus.wb_dest); end
      tick(); #1;
      tests++; if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 5'd1 || bus.load_wb !== 1'b0 || bus.wb_tag !== 5'd2) begin
         fails++; $display("FAIL full_after_commit got %0b/%0d/%0b/%0d exp 1/1/0/2", bus.alloc_ready, bus.alloc_tag, bus.load_wb, bus.wb_tag); end
      dispatch(5'd9, 1'b0); #1;
      tests++; if (bus.alloc_ready !== 1'b0 || bus.alloc_tag !== 5'd2) begin fails++; $display("FAIL full_refill got %0b/%0d exp 0/2", bus.alloc_ready, bus.alloc_tag); end
   endtask

   task automatic test_mispredict();
      do_reset();
      dispatch(5'd1, 1'b1);
      dispatch(5'd2, 1'b0);
      dispatch(5'd3, 1'b0);
      bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd2; bus.cdb_data = 32'd2;
      tick();
      bus.cdb_tag = 5'd1; bus.cdb_data = 32'h44; bus.cdb_mispredict = 1'b1; bus.cdb_target = 32'h40;
      tick();
      bus.cdb_tag = 5'd3; bus.cdb_data = 32'h3; bus.cdb_mispredict = 1'b0; bus.cdb_target = 32'h0;
      bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd7; #1;
      tests++; if (bus.load_wb !== 1'b1 || bus.flush !== 1'b1 || bus.redirect_pc !== 32'h40) begin
         fails++; $display("FAIL mispred_flush got %0b/%0b/%h exp 1/1/40", bus.load_wb, bus.flush, bus.redirect_pc); end
      tests++; if (bus.wb_tag !== 5'd1 || bus.wb_dest !== 5'd1 || bus.wb_data !== 32'h44 || bus.alloc_ready !== 1'b0) begin
         fails++; $display("FAIL mispred_wb got %0d/%0d/%h/%0b exp 1/1/44/0", bus.wb_tag, bus.wb_dest, bus.wb_data, bus.alloc_ready); end
      tick();
      idle(); bus.q_tag_a = 5'd2; #1;
      tests++; if (bus.flush !== 1'b0 || bus.load_wb !== 1'b0 || bus.redirect_pc !== 32'd0) begin
         fails++; $display("FAIL mispred_pulse got %0b/%0b/%h exp 0/0/0", bus.flush, bus.load_wb, bus.redirect_pc); end
      tests++; if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 5'd1 || dut.count !== 4'd0 || bus.q_ready_a !== 1'b0) begin
         fails++; $display("FAIL mispred_cleared got %0b/%0d/%0d/%0b exp 1/1/0/0", bus.alloc_ready, bus.alloc_tag, dut.count, bus.q_ready_a); end
      tick(); tick(); #1;
      tests++; if (bus.load_wb !== 1'b0) begin fails++; $display("FAIL mispred_no_stale_commit got %0b exp 0", bus.load_wb); end
      dispatch(5'd0, 1'b0);
      bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd1; bus.cdb_data = 32'd5; bus.cdb_mispredict = 1'b1; bus.cdb_target = 32'h80;
      tick();
      idle(); #1;
      tests++; if (bus.load_wb !== 1'b1 || bus.flush !== 1'b0 || bus.redirect_pc !== 32'd0 || bus.wb_dest !== 5'd0 || bus.wb_data !== 32'd5) begin
         fails++; $display("FAIL nonbranch_mispred got %0b/%0b/%h/%0d/%0d exp 1/0/0/0/5", bus.load_wb, bus.flush, bus.redirect_pc, bus.wb_dest, bus.wb_data); end
   endtask

   task automatic test_lookup_and_reset();
      do_reset();
      dispatch(5'd1, 1'b0);
      dispatch(5'd2, 1'b0);
      dispatch(5'd3, 1'b0);
      bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd2; bus.cdb_data = 32'd7;
      tick();
      bus.cdb_valid = 1'b0; bus.q_tag_a = 5'd2; bus.q_tag_b = 5'd3; #1;
      tests++; if (bus.q_ready_a !== 1'b1 || bus.q_data_a !== 32'd7) begin fails++; $display("FAIL lookup_a got %0b/%0d exp 1/7", bus.q_ready_a, bus.q_data_a); end
      tests++; if (bus.q_ready_b !== 1'b0 || bus.q_data_b !== 32'd0) begin fails++; $display("FAIL lookup_b_busy got %0b/%0d exp 0/0", bus.q_ready_b, bus.q_data_b); end
      bus.q_tag_b = 5'd0; #1;
      tests++; if (bus.q_ready_b !== 1'b0) begin fails++; $display("FAIL lookup_b_tag0 got %0b exp 0", bus.q_ready_b); end
      bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd0; bus.cdb_data = 32'h1111;
      tick();
      bus.cdb_tag = 5'd9; bus.cdb_data = 32'h2222;
      tick();
      bus.cdb_valid = 1'b0; bus.q_tag_a = 5'd1; bus.q_tag_b = 5'd2; #1;
      tests++; if (bus.q_ready_a !== 1'b0 || bus.load_wb !== 1'b0) begin fails++; $display("FAIL badtag_head got %0b/%0b exp 0/0", bus.q_ready_a, bus.load_wb); end
      tests++; if (bus.q_ready_b !== 1'b1 || bus.q_data_b !== 32'd7) begin fails++; $display("FAIL badtag_data got %0b/%h exp 1/7", bus.q_ready_b, bus.q_data_b); end
      bus.q_tag_a = 5'd3; #1;
      tests++; if (bus.q_ready_a !== 1'b0) begin fails++; $display("FAIL badtag_tag3 got %0b exp 0", bus.q_ready_a); end
      dispatch(5'd4, 1'b0);
      rst = 1'b1;
      bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd6;
      bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd1; bus.cdb_data = 32'd9;
      tick();
      rst = 1'b0; idle(); bus.q_tag_a = 5'd2; #1;
      tests++; if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 5'd1 || bus.wb_tag !== 5'd1) begin
         fails++; $display("FAIL midrst_ptrs got %0b/%0d/%0d exp 1/1/1", bus.alloc_ready, bus.alloc_tag, bus.wb_tag); end
      tests++; if (bus.load_wb !== 1'b0 || bus.q_ready_a !== 1'b0 || bus.q_data_a !== 32'd0) begin
         fails++; $display("FAIL midrst_state got %0b/%0b/%0d exp 0/0/0", bus.load_wb, bus.q_ready_a, bus.q_data_a); end
      tick(); #1;
      tests++; if (bus.load_wb !== 1'b0) begin fails++; $display("FAIL midrst_no_commit got %0b exp 0", bus.load_wb); end
   endtask

   initial begin
      idle();
      test_reset();
      test_basic();
      test_out_of_order();
      test_full();
      test_mispredict();
      test_lookup_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
